// File: rtl/fxp_mul_arb.sv
// Round-robin arbiter sharing one signed Q(QINT.QFRAC) multiplier among NREQ requesters.
// Define FXP_MUL_ARB_PIPE_EN to insert an operand register stage (latency 2 instead of 1).
module fxp_mul_arb #(
  parameter  int QINT  = 8,
  parameter  int QFRAC = 16,
  parameter  int NREQ  = 4,
  localparam int W     = QINT + QFRAC,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic [IDW-1:0]    res_id
);

  logic [IDW-1:0]        ptr;
  logic [IDW-1:0]        win;
  logic [IDW-1:0]        ptr_nxt;
  logic                  any_valid;
  logic                  stall;
  logic                  can_accept;
  logic                  grant;
  logic signed [W-1:0]   mul_a;
  logic signed [W-1:0]   mul_b;
  logic signed [W+QFRAC-1:0] prod;
  logic [W-1:0]          mul_res;

  assign stall = res_valid && !res_ready;
  assign grant = any_valid && can_accept && !rst;

  // Search starts at ptr and wraps modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win       = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win       = IDW'(idx);
      end
    end
  end

  assign ptr_nxt = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)        ptr <= '0;
    else if (grant) ptr <= ptr_nxt;
  end

  // Only the low W+QFRAC product bits are needed; the shift keeps bits [QFRAC+W-1:QFRAC].
  assign prod    = mul_a * mul_b;
  assign mul_res = W'(prod >>> QFRAC);

`ifdef FXP_MUL_ARB_PIPE_EN
  logic                p_valid;
  logic signed [W-1:0] p_a;
  logic signed [W-1:0] p_b;
  logic [IDW-1:0]      p_id;

  // Operand stage may fill under a stall only while it is empty.
  assign can_accept = !stall || !p_valid;
  assign mul_a      = p_a;
  assign mul_b      = p_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_a     <= '0;
      p_b     <= '0;
      p_id    <= '0;
    end else if (can_accept) begin
      p_valid <= grant;
      if (grant) begin
        p_a  <= req_a[win*W +: W];
        p_b  <= req_b[win*W +: W];
        p_id <= win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (!stall) begin
      res_valid <= p_valid;
      if (p_valid) begin
        res_data <= mul_res;
        res_id   <= p_id;
      end
    end
  end
`else
  assign can_accept = !stall;
  assign mul_a      = req_a[win*W +: W];
  assign mul_b      = req_b[win*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (!stall) begin
      res_valid <= grant;
      if (grant) begin
        res_data <= mul_res;
        res_id   <= win;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fxp_mul_arb.sv
// Scoreboard testbench for fxp_mul_arb; honours FXP_MUL_ARB_PIPE_EN for the latency checks.
module tb_fxp_mul_arb;
  localparam int QINT  = 8;
  localparam int QFRAC = 16;
  localparam int NREQ  = 4;
  localparam int W     = QINT + QFRAC;
  localparam int IDW   = 2;
`ifdef FXP_MUL_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_data;
  logic [IDW-1:0]    res_id;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } exp_t;

  exp_t           exp_q[$];
  logic [IDW-1:0] got_ids[$];
  logic [NREQ-1:0] drop_mask;
  int n_checks = 0;
  int n_errors = 0;

  fxp_mul_arb #(.QINT(QINT), .QFRAC(QFRAC), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] fxp_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p[QFRAC+W-1:QFRAC];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_id", res_id, e.id);
          check("sb_data", res_data, e.data);
          got_ids.push_back(res_id);
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i])
          exp_q.push_back('{id: IDW'(i), data: fxp_model(req_a[i*W +: W], req_b[i*W +: W])});
    end
  end

  // One cycle: sample transfers at negedge, then drop valid of finished requesters.
  task automatic tick(output logic [NREQ-1:0] x);
    @(negedge clk);
    x = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(x & drop_mask);
  endtask

  task automatic idle(input int n);
    logic [NREQ-1:0] x;
    repeat (n) tick(x);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic single_op(input string tag, input int i, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_d);
    logic [NREQ-1:0] x;
    bit done;
    done = 1'b0;
    set_req(i, a, b);
    for (int n = 0; n < 20 && !done; n++) begin
      tick(x);
      done = x[i];
    end
    check({tag, "_xfer"}, done, 1);
    repeat (LAT - 1) tick(x);
    @(negedge clk);
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_data"}, res_data, exp_d);
    check({tag, "_id"}, res_id, i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] x;
    logic [W-1:0]    hold_d;
    logic [IDW-1:0]  hold_id;
    int              order[8];
    int              exp_order[8];

    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    drop_mask = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_id", res_id, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    idle(2);

    single_op("op_basic", 0, 24'h018000, 24'h020000, 24'h030000);
    idle(2);
    single_op("op_sign", 2, 24'hFF0000, 24'h020000, 24'hFE0000);
    idle(2);
    single_op("op_ovf", 2, 24'h7F0000, 24'h7F0000, 24'h010000);
    idle(3);

    // Round-robin with every requester held valid.
    do_reset();
    drop_mask = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, W'((i + 1) << QFRAC), W'(24'h008000 + i));
    for (int c = 0; c < 8; c++) begin
      tick(x);
      check("rr_onehot", $countones(x), 1);
      order[c] = -1;
      for (int i = 0; i < NREQ; i++) if (x[i]) order[c] = i;
    end
    req_valid = '0;
    drop_mask = '1;
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int c = 0; c < 8; c++) check("rr_order", order[c], exp_order[c]);
    idle(LAT + 2);

    // Backpressure with requesters 1 and 3 pending.
    got_ids.delete();
    res_ready = 1'b0;
    set_req(1, 24'h00C000, 24'hFFA000);
    set_req(3, 24'h123456, 24'h00F000);
    idle(3);
    hold_d  = res_data;
    hold_id = res_id;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_ready", req_ready, 0);
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, hold_d);
      check("bp_id", res_id, hold_id);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    idle(6);
    check("bp_count", got_ids.size(), 2);
    if (got_ids.size() == 2) begin
      check("bp_first", got_ids[0], 1);
      check("bp_second", got_ids[1], 3);
    end
    check("bp_pending", req_valid, 0);

    // Fairness skip: ptr is 0 here after grants 1 then 3.
    set_req(3, 24'h010000, 24'h010000);
    tick(x);
    check("fair_skip", x, 4'b1000);
    idle(2);
    set_req(0, 24'h020000, 24'h030000);
    set_req(3, 24'hFE8000, 24'h010000);
    tick(x);
    check("fair_wrap", x, 4'b0001);
    idle(LAT + 3);
    check("fair_done", req_valid, 0);

    // Reset while results are in flight and requests are pending.
    drop_mask = '0;
    set_req(1, 24'h011000, 24'h022000);
    set_req(2, 24'hF00000, 24'h004000);
    idle(3);
    check("mr_pre_valid", res_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mr_rst_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_valid", res_valid, 0);
    check("mr_data", res_data, 0);
    check("mr_id", res_id, 0);
    check("mr_first_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = '0;
    drop_mask = '1;
    idle(LAT + 4);
    check("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
